pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Parametrised program-counter unit: next-generation PC register with next-PC select,
//  fetch valid/ready handshake, halt/resume control and a circular return-address stack.
//  Sits between control/branch logic and instruction memory. Drives the fetch address.
//  Supports sequential, branch, return and hold modes; call links push PC+INC.
// PARAMETERS
//  DATA_WIDTH    32   PC / address width in bits
//  RESET_VECTOR  0    PC value loaded on reset
//  INC           4    sequential increment in bytes; power of two, >=1
//  RAS_DEPTH     4    return-address stack entries; power of two, >=2
// PORTS
//  clk            in   1           clock, rising edge
//  rst            in   1           asynchronous reset, active-low
//  pc_src         in   2           00 seq, 01 branch to branch_target, 10 return (RAS pop), 11 hold
//  branch_target  in   DATA_WIDTH  redirect target used when pc_src==01
//  call           in   1           push PC+INC onto RAS on this update event
//  halt           in   1           request halt; PC frozen
//  resume         in   1           leave HALTED
//  fetch_ready    in   1           imem accepts the current PC this cycle
//  fetch_valid    out  1           PC is a valid fetch request
//  PC             out  DATA_WIDTH  current fetch address
//  misaligned     out  1           1-cycle pulse: branch target not INC-aligned, redirect dropped
//  ras_underflow  out  1           1-cycle pulse: return issued with empty RAS
//  ras_empty      out  1           RAS count == 0
//  ras_full       out  1           RAS count == RAS_DEPTH
// BEHAVIOUR
//  Reset: rst low (async) -> PC=RESET_VECTOR, fetch_valid=0, misaligned=0, ras_underflow=0,
//   RAS count=0, ras_empty=1, ras_full=0, state=BOOT. Reset mid-operation discards everything.
//  FSM: BOOT -> RUN unconditionally on the first clk edge after rst deasserts (fetch_valid=0 in BOOT).
//   RUN -> HALTED when halt=1 (fetch_valid=0 from the next cycle, PC frozen).
//   HALTED -> RUN when resume=1 and halt=0; halt has priority if both are high.
//  Update event (RUN only, halt=0): accept = fetch_valid & fetch_ready, OR redirect (pc_src 01/10).
//   Redirects take effect regardless of fetch_ready; the in-flight fetch is abandoned.
//   A redirect or hold in the same cycle as halt is ignored. halt wins.
//  Next PC on an update event, latency 1 cycle:
//   00: PC+INC only if accept, else PC held. 11: PC held, no RAS effect, call ignored.
//   01: if branch_target[log2(INC)-1:0]!=0 -> PC held, misaligned=1 next cycle, call ignored;
//       else PC=branch_target.
//   10: RAS non-empty -> PC=top, count-1. Empty -> PC=PC+INC, ras_underflow=1 next cycle.
//  Arithmetic: PC+INC is modulo 2^DATA_WIDTH. PC=all-ones-minus-(INC-1) wraps to 0.
//  RAS: call on a valid update pushes old PC+INC.
//   Full push overwrites the oldest entry (circular) and count stays RAS_DEPTH.
//   Call and return in the same cycle: target = old top, then top is replaced with PC+INC.
//   Count is unchanged; with an empty RAS this gives an underflow pulse, then count=1.
//  Outputs are registered; ras_empty and ras_full are decoded from the registered count.
// TESTING
//  1. Reset with INC=4, RESET_VECTOR=0x100; release rst, fetch_ready=1, pc_src=00
//     -> BOOT 1 cycle, then fetch_valid=1, PC 0x100,0x104,0x108.
//  2. fetch_ready=0 for 3 cycles with pc_src=00 -> PC holds 0x108.
//     fetch_ready=0, pc_src=01, target=0x200 -> PC=0x200 next cycle.
//  3. pc_src=01, target=0x203 -> PC holds, misaligned pulses 1 cycle.
//     Same with call=1 -> RAS count unchanged.
//  4. RAS_DEPTH=4: five calls at PCs 0x10..0x50 (target 0x400), then five returns
//     -> returns to 0x54,0x44,0x34,0x24, then underflow pulse and PC=prev+4.
//  5. halt=1 mid-stream at PC=0x120 -> fetch_valid=0, PC stays 0x120.
//     halt=1 with resume=1 stays halted; resume alone -> RUN, fetch resumes at 0x120.
//  6. DATA_WIDTH=8, PC=0xFC, seq accept -> PC=0x00.
//     Assert rst low mid-burst -> PC=RESET_VECTOR immediately (async), RAS empty.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter unit: registered next-PC select (seq/branch/return/hold), fetch handshake,
// halt/resume control and a circular return-address stack. PC update latency is one cycle.
module pc_fetch_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    INC          = 4,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_pc_src,
    input  logic [DATA_WIDTH-1:0] i_branch_target,
    input  logic                  i_call,
    input  logic                  i_halt,
    input  logic                  i_resume,
    input  logic                  i_fetch_ready,
    output logic                  o_fetch_valid,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic                  o_misaligned,
    output logic                  o_ras_underflow,
    output logic                  o_ras_empty,
    output logic                  o_ras_full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] W_INC      = DATA_WIDTH'(INC);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = W_INC - 1'b1;
    localparam logic [CW-1:0]         RAS_MAX    = CW'(RAS_DEPTH);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALTED} state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc, w_pc_nxt, w_pc_inc, w_ras_top;
    logic [DATA_WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]         r_sp, w_sp_nxt, w_wr_idx;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic                  r_fetch_valid, r_misaligned, r_underflow;
    logic                  w_push, w_pop, w_mis, w_unf, w_accept, w_empty, w_full;

    assign w_pc_inc  = r_pc + W_INC;
    assign w_ras_top = r_ras[r_sp];
    assign w_accept  = r_fetch_valid & i_fetch_ready;
    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == RAS_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_mis       = 1'b0;
        w_unf       = 1'b0;
        case (r_state)
            ST_BOOT:   w_state_nxt = ST_RUN;
            ST_HALTED: if (i_resume && !i_halt) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (i_halt) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    case (i_pc_src)
                        2'b00: if (w_accept) begin
                            w_pc_nxt = w_pc_inc;
                            w_push   = i_call;
                        end
                        2'b01: if (|(i_branch_target & ALIGN_MASK)) begin
                            w_mis = 1'b1;
                        end else begin
                            w_pc_nxt = i_branch_target;
                            w_push   = i_call;
                        end
                        2'b10: begin
                            if (w_empty) begin
                                w_unf    = 1'b1;
                                w_pc_nxt = w_pc_inc;
                            end else begin
                                w_pc_nxt = w_ras_top;
                                w_pop    = 1'b1;
                            end
                            w_push = i_call;
                        end
                        default: ;
                    endcase
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // Push+pop together rewrites the top slot in place; a full push silently laps the oldest.
    always_comb begin
        w_sp_nxt  = r_sp;
        w_cnt_nxt = r_cnt;
        w_wr_idx  = r_sp + 1'b1;
        if (w_push && w_pop) begin
            w_wr_idx = r_sp;
        end else if (w_push) begin
            w_sp_nxt  = r_sp + 1'b1;
            w_cnt_nxt = w_full ? r_cnt : r_cnt + 1'b1;
        end else if (w_pop) begin
            w_sp_nxt  = r_sp - 1'b1;
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_VECTOR;
            r_fetch_valid <= 1'b0;
            r_misaligned  <= 1'b0;
            r_underflow   <= 1'b0;
            r_sp          <= '0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_fetch_valid <= (w_state_nxt == ST_RUN);
            r_misaligned  <= w_mis;
            r_underflow   <= w_unf;
            r_sp          <= w_sp_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_ras[w_wr_idx] <= w_pc_inc;
    end

    assign o_fetch_valid   = r_fetch_valid;
    assign o_pc            = r_pc;
    assign o_misaligned    = r_misaligned;
    assign o_ras_underflow = r_underflow;
    assign o_ras_empty     = w_empty;
    assign o_ras_full      = w_full;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random traffic against a queue-based PC/RAS model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pc_src;
    logic [31:0] tgt;
    logic        call, halt, resume, ready;
    logic        fv, mis, unf, empty, full;
    logic [31:0] pc;

    logic        d8_rst_n;
    logic [1:0]  d8_src;
    logic [7:0]  d8_tgt;
    logic        d8_fv, d8_mis, d8_unf, d8_empty, d8_full;
    logic [7:0]  d8_pc;

    int checks = 0;
    int errors = 0;
    int stepno = 0;

    // Reference model state
    bit          m_boot, m_run, m_fv, m_mis, m_unf;
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_fetch_unit #(.DATA_WIDTH(32), .RESET_VECTOR(RV), .INC(4), .RAS_DEPTH(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pc_src(pc_src), .i_branch_target(tgt),
        .i_call(call), .i_halt(halt), .i_resume(resume), .i_fetch_ready(ready),
        .o_fetch_valid(fv), .o_pc(pc), .o_misaligned(mis), .o_ras_underflow(unf),
        .o_ras_empty(empty), .o_ras_full(full)
    );

    pc_fetch_unit #(.DATA_WIDTH(8), .RESET_VECTOR(8'h00), .INC(4), .RAS_DEPTH(4)) u_dut8 (
        .i_clk(clk), .i_rst_n(d8_rst_n), .i_pc_src(d8_src), .i_branch_target(d8_tgt),
        .i_call(1'b0), .i_halt(1'b0), .i_resume(1'b0), .i_fetch_ready(1'b1),
        .o_fetch_valid(d8_fv), .o_pc(d8_pc), .o_misaligned(d8_mis), .o_ras_underflow(d8_unf),
        .o_ras_empty(d8_empty), .o_ras_full(d8_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, stepno, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_run = 0; m_fv = 0; m_mis = 0; m_unf = 0;
        m_pc = RV;
        m_ras.delete();
    endtask

    task automatic push(input logic [31:0] v);
        m_ras.push_back(v);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
    endtask

    task automatic model_step();
        logic [31:0] nxt;
        bit acc;
        m_mis = 0; m_unf = 0;
        acc = m_fv && ready;
        if (m_boot) begin
            m_boot = 0; m_run = 1;
        end else if (!m_run) begin
            if (resume && !halt) m_run = 1;
        end else if (halt) begin
            m_run = 0;
        end else begin
            case (pc_src)
                2'd0: if (acc) begin
                    if (call) push(m_pc + 4);
                    m_pc = m_pc + 4;
                end
                2'd1: if ((tgt % 4) != 0) m_mis = 1;
                      else begin
                          if (call) push(m_pc + 4);
                          m_pc = tgt;
                      end
                2'd2: begin
                    if (m_ras.size() == 0) begin
                        m_unf = 1;
                        nxt = m_pc + 4;
                    end else begin
                        nxt = m_ras.pop_back();
                    end
                    if (call) push(m_pc + 4);
                    m_pc = nxt;
                end
                default: ;
            endcase
        end
        m_fv = m_run;
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("fetch_valid", 32'(fv), 32'(m_fv));
        chk("misaligned", 32'(mis), 32'(m_mis));
        chk("ras_underflow", 32'(unf), 32'(m_unf));
        chk("ras_empty", 32'(empty), 32'(m_ras.size() == 0));
        chk("ras_full", 32'(full), 32'(m_ras.size() == 4));
    endtask

    task automatic step(input logic [1:0] s, input logic [31:0] t, input logic c,
                        input logic h, input logic r, input logic rdy);
        pc_src = s; tgt = t; call = c; halt = h; resume = r; ready = rdy;
        @(posedge clk);
        model_step();
        stepno++;
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; d8_rst_n = 1'b0;
        pc_src = 2'd0; tgt = '0; call = 0; halt = 0; resume = 0; ready = 0;
        d8_src = 2'd0; d8_tgt = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Boot then sequential stream
        for (int i = 0; i < 3; i++) step(2'd0, '0, 0, 0, 0, 1);
        chk("seq_pc_0x108", pc, 32'h108);
        for (int i = 0; i < 3; i++) step(2'd0, '0, 0, 0, 0, 0);
        step(2'd1, 32'h200, 0, 0, 0, 0);
        chk("branch_no_ready", pc, 32'h200);

        // Misaligned redirect, with and without call
        step(2'd1, 32'h203, 0, 0, 0, 1);
        step(2'd3, '0, 0, 0, 0, 1);
        step(2'd1, 32'h203, 1, 0, 0, 1);
        step(2'd3, '0, 1, 0, 0, 1);

        // Five calls overflow the 4-deep stack, then five returns
        for (int i = 1; i <= 5; i++) begin
            step(2'd1, 32'h10 * i, 0, 0, 0, 1);
            step(2'd1, 32'h400, 1, 0, 0, 1);
        end
        for (int i = 0; i < 5; i++) step(2'd2, '0, 0, 0, 0, 1);
        chk("underflow_pc", pc, 32'h28);

        // Call+return combos on an empty and a non-empty stack
        step(2'd2, '0, 1, 0, 0, 1);
        step(2'd1, 32'h300, 1, 0, 0, 1);
        step(2'd2, '0, 1, 0, 0, 1);
        step(2'd2, '0, 0, 0, 0, 1);

        // Halt / resume
        step(2'd1, 32'h120, 0, 0, 0, 1);
        step(2'd1, 32'h500, 0, 1, 0, 1);
        step(2'd0, '0, 0, 1, 1, 1);
        step(2'd0, '0, 0, 0, 0, 1);
        chk("halted_pc", pc, 32'h120);
        step(2'd0, '0, 0, 0, 1, 1);
        step(2'd0, '0, 0, 0, 0, 1);
        chk("resumed_pc", pc, 32'h124);

        // 32-bit wrap
        step(2'd1, 32'hFFFF_FFFC, 0, 0, 0, 1);
        step(2'd0, '0, 0, 0, 0, 1);
        chk("wrap32", pc, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rt;
            rt = $urandom;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            step(2'($urandom_range(0, 3)), rt, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-burst
        step(2'd1, 32'h40, 1, 0, 0, 1);
        step(2'd0, '0, 1, 0, 0, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("async_rst_pc", pc, RV);
        #2 rst_n = 1'b1;
        step(2'd0, '0, 0, 0, 0, 1);
        step(2'd0, '0, 0, 0, 0, 1);

        // 8-bit instance wrap
        d8_rst_n = 1'b1;
        @(posedge clk); #1;
        chk("d8_boot_pc", 32'(d8_pc), 32'h00);
        chk("d8_boot_fv", 32'(d8_fv), 32'h1);
        d8_src = 2'd1; d8_tgt = 8'hFC;
        @(posedge clk); #1;
        chk("d8_branch_pc", 32'(d8_pc), 32'hFC);
        d8_src = 2'd0;
        @(posedge clk); #1;
        chk("d8_wrap_pc", 32'(d8_pc), 32'h00);
        chk("d8_empty", 32'(d8_empty), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
